// File: rtl/mem_line_bridge.sv
// Cache-line to word-bus bridge: splits 128-bit refill/write-back requests into
// four sequential 32-bit req/ack beats and returns assembled lines or completion pulses.
module mem_line_bridge #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_write_addr,
  input  logic [LINE_WIDTH-1:0] mem_wr_data,
  output logic [LINE_WIDTH-1:0] mem_rd_data,
  output logic                  mem_rd_data_valid,
  output logic                  mem_wr_data_ready,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [WORD_WIDTH-1:0] bus_wdata,
  input  logic [WORD_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err
);

  localparam int unsigned BEATS      = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned OFF_W      = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BASE_W     = ADDR_WIDTH - OFF_W;
  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
  localparam int unsigned TO_LAST    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned WAIT_W     = $clog2(TO_LAST + 2);
  localparam bit          TO_EN      = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BEAT = 3'd1,
    WR_DONE = 3'd2,
    RD_BEAT = 3'd3,
    RD_DONE = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BASE_W-1:0]     base_q, base_d;
  logic [LINE_WIDTH-1:0] wline_q, wline_d;
  logic [LINE_WIDTH-1:0] rline_q, rline_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  err_q, err_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic                  timeout_c;
  logic                  beat_end_c;
  logic                  unused_addr_bits;

  // Sub-line address bits are never used: lines are always fetched from offset 0.
  assign unused_addr_bits = ^{mem_read_addr[OFF_W-1:0], mem_write_addr[OFF_W-1:0]};

  // A beat that waits TIMEOUT cycles without ack is forced to complete.
  assign timeout_c = TO_EN && !bus_ack && (wait_q == WAIT_W'(TO_LAST));

  // Next-state, line assembly and registered-output decode.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    wline_d    = wline_q;
    rline_d    = rline_q;
    wait_d     = wait_q;
    err_d      = err_q;
    beat_end_c = 1'b0;
    req_d      = 1'b0;
    we_d       = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;
    valid_d    = 1'b0;
    ready_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Write-back wins so the dirty line reaches memory before its refill.
        if (mem_write) begin
          base_d  = mem_write_addr[ADDR_WIDTH-1:OFF_W];
          wline_d = mem_wr_data;
          beat_d  = '0;
          wait_d  = '0;
          state_d = WR_BEAT;
        end else if (mem_read) begin
          base_d  = mem_read_addr[ADDR_WIDTH-1:OFF_W];
          beat_d  = '0;
          wait_d  = '0;
          state_d = RD_BEAT;
        end
      end
      WR_BEAT, RD_BEAT: begin
        beat_end_c = bus_ack || timeout_c;
        if (beat_end_c) begin
          if (state_q == RD_BEAT) begin
            for (int unsigned i = 0; i < BEATS; i++) begin
              if (beat_q == BEAT_W'(i)) begin
                rline_d[i*WORD_WIDTH +: WORD_WIDTH] = bus_ack ? bus_rdata : '0;
              end
            end
          end
          if (timeout_c) begin
            err_d = 1'b1;
          end
          wait_d = '0;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = (state_q == WR_BEAT) ? WR_DONE : RD_DONE;
          end
        end else if (TO_EN) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WR_DONE: state_d = IDLE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_d   = (state_d == WR_BEAT) || (state_d == RD_BEAT);
    we_d    = (state_d == WR_BEAT);
    valid_d = (state_d == RD_DONE);
    ready_d = (state_d == WR_DONE);
    if (req_d) begin
      addr_d = {base_d, OFF_W'(0)} + ADDR_WIDTH'(beat_d) * ADDR_WIDTH'(WORD_BYTES);
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (we_d && beat_d == BEAT_W'(i)) begin
          wdata_d = wline_d[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  // State and output registers; reset abandons any in-flight line silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign mem_rd_data       = rline_q;
  assign mem_rd_data_valid = valid_q;
  assign mem_wr_data_ready = ready_q;
  assign bus_req           = req_q;
  assign bus_we            = we_q;
  assign bus_addr          = addr_q;
  assign bus_wdata         = wdata_q;
  assign bus_err           = err_q;

endmodule

// File: tb/tb_mem_line_bridge.sv
// Randomized bench for mem_line_bridge: a behavioural bus responder plus a
// line-level model predicting latency, beat sequence, assembled data and bus_err.
module tb_mem_line_bridge;

  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mem_read = 1'b0;
  logic [31:0]  mem_read_addr = '0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_write_addr = '0;
  logic [127:0] mem_wr_data = '0;
  logic [127:0] mem_rd_data;
  logic         mem_rd_data_valid;
  logic         mem_wr_data_ready;
  logic         bus_req;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [31:0]  bus_rdata = '0;
  logic         bus_ack = 1'b0;
  logic         bus_err;

  always #5 clk = ~clk;

  mem_line_bridge #(
    .LINE_WIDTH(128), .WORD_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
    .mem_wr_data_ready(mem_wr_data_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  int           passed = 0;
  int           total  = 0;
  int           waits[4];
  bit           hold[4];
  logic [31:0]  rword[4];
  bit           spurious = 1'b0;
  logic [31:0]  log_addr[$];
  logic [31:0]  log_wdata[$];
  logic         log_we[$];
  bit           err_m = 1'b0;
  logic [127:0] rd_m  = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Memory responder: beat b acks after waits[b] idle cycles, never if hold[b].
  bit          active = 1'b0;
  logic [31:0] cur_addr = '0;
  int          waited = 0;
  always @(negedge clk) begin
    int b;
    if (!bus_req) begin
      active    = 1'b0;
      waited    = 0;
      bus_ack   = spurious;
      bus_rdata = 32'hDEAD_BEEF;
    end else begin
      if (!active || bus_addr != cur_addr) begin
        active   = 1'b1;
        cur_addr = bus_addr;
        waited   = 0;
      end
      b = int'(bus_addr[3:2]);
      if (!hold[b] && waited >= waits[b]) bus_ack = 1'b1;
      else begin
        bus_ack = 1'b0;
        waited++;
      end
      bus_rdata = bus_ack ? rword[b] : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    if (rst && bus_req && bus_ack) begin
      log_addr.push_back(bus_addr);
      log_we.push_back(bus_we);
      log_wdata.push_back(bus_wdata);
    end
  end

  function automatic int beat_cycles();
    int c = 0;
    for (int b = 0; b < 4; b++) c += hold[b] ? int'(TO) : waits[b] + 1;
    return c;
  endfunction

  function automatic logic [127:0] exp_rline();
    logic [127:0] r = '0;
    for (int b = 0; b < 4; b++) r[32*b +: 32] = hold[b] ? 32'h0 : rword[b];
    return r;
  endfunction

  function automatic bit any_hold();
    return hold[0] | hold[1] | hold[2] | hold[3];
  endfunction

  task automatic randomize_bus(input int hold_odds);
    for (int b = 0; b < 4; b++) begin
      waits[b] = int'($urandom_range(0, 3));
      hold[b]  = (hold_odds != 0) && ($urandom_range(1, hold_odds) == 1);
      rword[b] = $urandom;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
  endtask

  // Counts edges until the done pulse, dropping the request the cycle it is seen.
  task automatic await_pulse(input bit wr, input bit scramble, input string tag, output int edges);
    bit seen = 1'b0;
    edges = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      edges++;
      if (scramble && i == 0) begin
        mem_read_addr  = $urandom;
        mem_write_addr = $urandom;
        mem_wr_data    = {$urandom, $urandom, $urandom, $urandom};
      end
      if (wr ? mem_wr_data_ready : mem_rd_data_valid) begin
        if (wr) mem_write = 1'b0;
        else    mem_read  = 1'b0;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, " pulse seen"}, 0, 1);
  endtask

  task automatic check_beats(input string tag, input bit wr, input logic [31:0] addr,
                             input logic [127:0] wline);
    int k = 0;
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    for (int b = 0; b < 4; b++) begin
      if (hold[b]) continue;
      if (k < log_addr.size()) begin
        check($sformatf("%s beat%0d addr", tag, b), log_addr[k], base + 32'(4 * b));
        check($sformatf("%s beat%0d we", tag, b), log_we[k], wr);
        if (wr) check($sformatf("%s beat%0d wdata", tag, b), log_wdata[k], wline[32*b +: 32]);
      end
      k++;
    end
    check({tag, " beat count"}, log_addr.size(), k);
  endtask

  task automatic post_line(input string tag, input bit wr);
    if (!wr) rd_m = exp_rline();
    if (any_hold()) err_m = 1'b1;
    check({tag, " rd_data"}, mem_rd_data, rd_m);
    check({tag, " bus_err"}, bus_err, err_m);
    @(posedge clk); #1;
    check({tag, " pulse width"}, {mem_rd_data_valid, mem_wr_data_ready}, 2'b00);
  endtask

  task automatic do_line(input bit wr, input logic [31:0] addr, input logic [127:0] wline,
                         input bit scramble, input string tag);
    int edges;
    clear_log();
    if (wr) begin
      mem_write_addr = addr;
      mem_wr_data    = wline;
      mem_write      = 1'b1;
    end else begin
      mem_read_addr = addr;
      mem_read      = 1'b1;
    end
    await_pulse(wr, scramble, tag, edges);
    check({tag, " latency"}, edges + 1, 2 + beat_cycles());
    check_beats(tag, wr, addr, wline);
    post_line(tag, wr);
  endtask

  initial begin
    int           edges;
    bit           found;
    logic [31:0]  waddr, raddr;
    logic [127:0] wl;

    for (int b = 0; b < 4; b++) begin
      waits[b] = 0;
      hold[b]  = 1'b0;
      rword[b] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset req/we", {bus_req, bus_we}, 2'b00);
    check("reset pulses", {mem_rd_data_valid, mem_wr_data_ready}, 2'b00);
    check("reset bus_addr", bus_addr, 0);
    check("reset rd_data", mem_rd_data, 0);
    check("reset bus_err", bus_err, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Refill with a zero-wait bus and known return words.
    rword[0] = 32'h11; rword[1] = 32'h22; rword[2] = 32'h33; rword[3] = 32'h44;
    do_line(1'b0, 32'h0000_1238, '0, 1'b0, "t1");
    check("t1 line literal", mem_rd_data, 128'h00000044_00000033_00000022_00000011);

    // Write-back with two wait cycles per beat.
    for (int b = 0; b < 4; b++) waits[b] = 2;
    for (int b = 0; b < 4; b++) wl[32*b +: 32] = 32'hA0 + 32'(b);
    do_line(1'b1, 32'h8000_00F0, wl, 1'b1, "t2");

    // Simultaneous write and read: write first, read re-sampled afterwards.
    randomize_bus(0);
    waddr = $urandom;
    raddr = $urandom;
    wl    = {$urandom, $urandom, $urandom, $urandom};
    clear_log();
    mem_write_addr = waddr;
    mem_wr_data    = wl;
    mem_read_addr  = raddr;
    mem_write      = 1'b1;
    mem_read       = 1'b1;
    await_pulse(1'b1, 1'b0, "t3 wr", edges);
    check("t3 wr latency", edges + 1, 2 + beat_cycles());
    check_beats("t3 wr", 1'b1, waddr, wl);
    clear_log();
    @(posedge clk); #1;
    check("t3 idle gap", {bus_req, mem_wr_data_ready}, 2'b00);
    @(posedge clk); #1;
    check("t3 rd start", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, raddr[31:4], 4'h0});
    await_pulse(1'b0, 1'b0, "t3 rd", edges);
    check("t3 rd latency", edges + 2, 2 + beat_cycles());
    check_beats("t3 rd", 1'b0, raddr, '0);
    post_line("t3 rd", 1'b0);

    // Asynchronous reset while read beat 2 is stalled.
    randomize_bus(0);
    waits[0] = 0; waits[1] = 0; waits[2] = 3;
    mem_read_addr = $urandom;
    mem_read      = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus_req && bus_addr[3:2] == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("t4 reached beat2", found, 1'b1);
    rst = 1'b0;
    #1;
    check("t4 async req/we", {bus_req, bus_we}, 2'b00);
    check("t4 async addr/wdata", {bus_addr, bus_wdata}, 64'h0);
    check("t4 async rd_data", mem_rd_data, 0);
    check("t4 async pulses/err", {mem_rd_data_valid, mem_wr_data_ready, bus_err}, 3'b000);
    mem_read = 1'b0;
    err_m = 1'b0;
    rd_m  = '0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("t4 no pulse %0d", i), {mem_rd_data_valid, bus_req}, 2'b00);
    end
    randomize_bus(0);
    do_line(1'b0, $urandom, '0, 1'b1, "t4 after");

    // Read beat 1 never acked: timeout, word1 forced to zero, sticky error.
    randomize_bus(0);
    hold[1] = 1'b1;
    do_line(1'b0, $urandom, '0, 1'b1, "t5");
    check("t5 word1 zero", mem_rd_data[63:32], 32'h0);
    check("t5 err set", bus_err, 1'b1);
    randomize_bus(0);
    do_line(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1, "t5 sticky");

    // Spurious ack while idle.
    spurious = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("t6 idle ack %0d", i),
            {bus_req, mem_rd_data_valid, mem_wr_data_ready}, 3'b000);
    end
    spurious = 1'b0;
    randomize_bus(0);
    do_line(1'b0, $urandom, '0, 1'b1, "t6 after");

    // Random mix of refills and write-backs with random waits and timeouts.
    for (int n = 0; n < 24; n++) begin
      randomize_bus(10);
      do_line(1'($urandom_range(0, 1)), $urandom,
              {$urandom, $urandom, $urandom, $urandom}, 1'b1, $sformatf("rnd%0d", n));
    end

    // Only reset clears the sticky error.
    rst = 1'b0;
    #1;
    check("final reset err", bus_err, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
